// File: rtl/acc_requant.sv
// acc_requant: round-half-up arithmetic right shift of a wide signed accumulator,
// saturated to a narrow signed activation, through a two-stage valid/ready pipeline.
module acc_requant #(
  parameter int IN_W  = 51,
  parameter int OUT_W = 8,
  parameter int SH_W  = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_acc,
  input  logic [SH_W-1:0]  in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_count
);

  // Handshake: a beat moves on any rising edge where valid && ready. A producer
  // holds valid and its payload until the beat moves; in_ready is combinational
  // from out_ready and the stage valid flags, so a full pipe still streams.

  localparam logic [SH_W-1:0]        sh_max = SH_W'(IN_W - 1);
  localparam logic signed [IN_W:0]   one_w  = (IN_W+1)'(1);
  localparam logic signed [IN_W:0]   sat_hi = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0]   sat_lo = ~sat_hi;
  localparam logic [OUT_W-1:0]       out_max = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]       out_min = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    s1_v;
  logic                    s2_v;
  logic signed [IN_W:0]    s1_r;
  logic                    adv1;
  logic                    adv2;

  logic [SH_W-1:0]         sh;
  logic signed [IN_W:0]    ext;
  logic signed [IN_W:0]    rnd;
  logic signed [IN_W:0]    sum;
  logic signed [IN_W:0]    r_next;
  logic [OUT_W-1:0]        d_next;
  logic                    sat_next;

  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v;

  // One guard bit above the accumulator keeps the rounding add from overflowing.
  always_comb begin
    sh  = (in_shift > sh_max) ? sh_max : in_shift;
    ext = {in_acc[IN_W-1], in_acc};
    rnd = '0;
    if (sh != '0) begin
      rnd = one_w << (sh - SH_W'(1));
    end
    sum    = ext + rnd;
    r_next = sum >>> sh;
  end

  always_comb begin
    d_next   = s1_r[OUT_W-1:0];
    sat_next = 1'b0;
    if (s1_r > sat_hi) begin
      d_next   = out_max;
      sat_next = 1'b1;
    end else if (s1_r < sat_lo) begin
      d_next   = out_min;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_r     <= '0;
      s2_v     <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (adv1) begin
        s1_v <= in_valid;
        s1_r <= r_next;
      end
      if (adv2) begin
        s2_v     <= s1_v;
        out_data <= d_next;
        out_sat  <= sat_next;
      end
    end
  end

  // Saturating event counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule
